// File: rtl/bg_vram_pkg.sv
// bg_vram_pkg
// Shared definitions for the background VRAM write path: the address map of
// the Pattern Memory Background (PMB, 512 B) and the Nametable (NTBL, 1 KiB),
// the queued write record, and the scheduler state encoding.
package bg_vram_pkg;

  localparam int VRAM_AW = 12;

  localparam int PMB_SIZE  = 512;
  localparam int PMB_AW    = $clog2(PMB_SIZE);
  localparam logic [VRAM_AW-1:0] PMB_BASE = 12'h000;
  localparam logic [VRAM_AW-1:0] PMB_MASK = 12'hE00;

  localparam int NTBL_SIZE = 1024;
  localparam int NTBL_AW   = $clog2(NTBL_SIZE);
  localparam logic [VRAM_AW-1:0] NTBL_BASE = 12'h400;
  localparam logic [VRAM_AW-1:0] NTBL_MASK = 12'hC00;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [7:0]         data;
  } bg_vram_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } bg_vram_state_e;

  function automatic logic addr_hits(input logic [VRAM_AW-1:0] addr,
                                     input logic [VRAM_AW-1:0] mask,
                                     input logic [VRAM_AW-1:0] base);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/bg_vram_wr_fifo.sv
// bg_vram_wr_fifo
// Synchronous first-word-fall-through FIFO of bg_vram_wr_t records.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data  enqueue (ignored when full)
//   pop              dequeue the head (ignored when empty)
//   head             current oldest entry, valid while !empty
//   full, empty      occupancy flags
//   count            occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module bg_vram_wr_fifo
  import bg_vram_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  bg_vram_wr_t              push_data,
  input  logic                     pop,
  output bg_vram_wr_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  bg_vram_wr_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; the head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/bg_vram_write_scheduler.sv
// bg_vram_write_scheduler
// Queues CPU byte writes to background VRAM and releases them into the PMB or
// NTBL arrays only while the video timing writable window is open, one byte
// per cycle. Unmapped writes are retired with a pulse and no strobe; a window
// that closes mid-drain sets the sticky backlog flag.
// Ports:
//   clk, rst                  pixel clock, asynchronous active-low reset
//   writable                  background VRAM write window
//   in_valid/in_ready         CPU write handshake, in_addr/in_data payload
//   pmb_we/pmb_addr           PMB write strobe and byte index
//   ntbl_we/ntbl_addr         NTBL write strobe and byte index
//   wr_data                   byte for whichever strobe is active
//   unmapped                  pulse when an unmapped write is retired
//   backlog/backlog_clr       sticky window-closed-with-pending flag, clear
//   pending                   FIFO occupancy
//   state                     IDLE=0, WAIT=1, DRAIN=2
// Build option: BG_VRAM_WRITE_BYPASS_EN lets a request arriving with the FIFO
// empty and the window open be written in the same cycle instead of queued.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | FIFO empty, nothing to release
// ST_WAIT  | writes queued, window closed
// ST_DRAIN | window open, releasing one queued write per cycle
module bg_vram_write_scheduler
  import bg_vram_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     writable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [VRAM_AW-1:0]       in_addr,
  input  logic [7:0]               in_data,
  output logic                     pmb_we,
  output logic [PMB_AW-1:0]        pmb_addr,
  output logic                     ntbl_we,
  output logic [NTBL_AW-1:0]       ntbl_addr,
  output logic [7:0]               wr_data,
  output logic                     unmapped,
  output logic                     backlog,
  input  logic                     backlog_clr,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [1:0]               state
);

  localparam int CW = $clog2(DEPTH) + 1;

  bg_vram_state_e state_q;
  bg_vram_state_e state_d;
  bg_vram_wr_t    head;
  bg_vram_wr_t    wr;
  logic           full;
  logic           empty;
  logic           accept;
  logic           bypass;
  logic           push_fifo;
  logic           retire;
  logic           wr_act;
  logic           is_pmb;
  logic           is_ntbl;
  logic           backlog_set;
  logic [CW-1:0]  cnt_next;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

`ifdef BG_VRAM_WRITE_BYPASS_EN
  // Gated with rst so a request presented during reset never strobes.
  assign bypass = rst && accept && empty && writable;
`else
  assign bypass = 1'b0;
`endif

  assign push_fifo = accept && !bypass;
  assign retire    = writable && !empty;
  assign wr_act    = retire || bypass;
  // A queued head always has priority; bypass only exists with an empty FIFO.
  assign wr        = retire ? head : '{addr: in_addr, data: in_data};

  bg_vram_wr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_fifo),
    .push_data ('{addr: in_addr, data: in_data}),
    .pop       (retire),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pending)
  );

  assign is_pmb  = addr_hits(wr.addr, PMB_MASK, PMB_BASE);
  assign is_ntbl = addr_hits(wr.addr, NTBL_MASK, NTBL_BASE);

  assign pmb_we    = wr_act && is_pmb;
  assign ntbl_we   = wr_act && is_ntbl;
  assign unmapped  = wr_act && !is_pmb && !is_ntbl;
  assign pmb_addr  = pmb_we  ? wr.addr[PMB_AW-1:0]  : '0;
  assign ntbl_addr = ntbl_we ? wr.addr[NTBL_AW-1:0] : '0;
  assign wr_data   = (pmb_we || ntbl_we) ? wr.data : '0;

  assign cnt_next = pending + CW'(push_fifo) - CW'(retire);

  always_comb begin
    state_d     = state_q;
    backlog_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (writable && cnt_next != '0) state_d = ST_DRAIN;
        else if (accept && !writable)   state_d = ST_WAIT;
      end
      // WAIT always holds at least one entry (nothing retires while the
      // window is closed), so an opening window always starts a drain.
      ST_WAIT: begin
        if (writable) state_d = ST_DRAIN;
      end
      // DRAIN likewise never holds an empty FIFO, so a closing window here
      // always leaves writes behind.
      ST_DRAIN: begin
        if (cnt_next == '0) begin
          state_d = ST_IDLE;
        end else if (!writable) begin
          state_d     = ST_WAIT;
          backlog_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      backlog <= 1'b0;
    end else begin
      state_q <= state_d;
      if (backlog_set)      backlog <= 1'b1;
      else if (backlog_clr) backlog <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: doc/bg_vram_write_scheduler.md
# bg_vram_write_scheduler

Buffers CPU-side byte writes to the background VRAM (Pattern Memory Background, 512 B, and Nametable, 1024 B) and releases them into those arrays only while the video timing `writable` window is open. It sits between the CPU bus bridge and the background renderer's memories, so CPU writes never collide with scanline fetches. The block decodes the 12-bit VRAM address into PMB/NTBL strobes, reports unmapped writes, and flags frames whose writable window closed with writes still pending.

## Interface
Parameters:
- `DEPTH`, 16: write FIFO entries; power of two, 2..64.

Ports:
- `clk` in 1: pixel clock, 12.5875 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `writable` in 1: video timing window in which background VRAM may be written.
- `in_valid` in 1: CPU write request.
- `in_ready` out 1: request accepted this cycle when `in_valid && in_ready`.
- `in_addr` in 12: VRAM byte address.
- `in_data` in 8: write byte.
- `pmb_we` out 1: PMB write strobe.
- `pmb_addr` out 9: PMB byte index.
- `ntbl_we` out 1: NTBL write strobe.
- `ntbl_addr` out 10: NTBL byte index.
- `wr_data` out 8: byte for either strobe.
- `unmapped` out 1: one-cycle pulse when an unmapped entry is retired.
- `backlog` out 1: sticky; the writable window closed with the FIFO non-empty.
- `backlog_clr` in 1: clears `backlog`.
- `pending` out clog2(DEPTH)+1: FIFO occupancy.
- `state` out 2: IDLE=0, WAIT=1, DRAIN=2.

## Operation
- Address map: `addr[11:9]==3'b000` targets PMB at `addr[8:0]`. `addr[11:10]==2'b01` targets NTBL at `addr[9:0]`. Every other address is unmapped.
- Push: an accepted request is enqueued (addr, data). `in_ready = !full`.
- Retire: `retire = writable && !empty`. The FIFO head pops in that same cycle. Exactly one strobe asserts, per the decode of the head. An unmapped head pops with no strobe and pulses `unmapped`.
- Strobes are combinational from the registered FIFO head and `writable`. They are never asserted while `writable` is 0.
- One retire per cycle, at most.
- Simultaneous push and retire: both happen and occupancy is unchanged. When full, `in_ready` is 0 even if a retire happens the same cycle (no pass-through).
- State register, next-state:
  - IDLE→WAIT: a push arrives with `writable` = 0.
  - IDLE/WAIT→DRAIN: `writable` = 1 and the next occupancy is non-zero.
  - DRAIN→WAIT: `writable` falls with occupancy non-zero. This also sets `backlog`.
  - DRAIN→IDLE: the next occupancy is 0.
  - WAIT→IDLE is unreachable.
- `backlog`: the set condition has priority over `backlog_clr` in the same cycle.
- `pending` wraps never. Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values: FIFO empty, `state` = IDLE, `backlog` = 0, `pending` = 0, `in_ready` = 1, all strobes 0, `unmapped` = 0, `wr_data`/addresses 0.
- Latency, baseline: a request accepted in cycle N is written in cycle N+1 at earliest, if `writable` is high in N+1.
- Drain rate: one byte per cycle while `writable` is high.
- Reset asserted mid-drain discards the FIFO contents. No strobe is produced during reset.

## Configuration
- `BG_VRAM_WRITE_BYPASS_EN` defined: a request with FIFO empty and `writable` = 1 is written in the same cycle N, combinationally from `in_addr`/`in_data`, and is not enqueued. Its decode, strobes and `unmapped` behave as for a FIFO head. `state` stays IDLE.
- Undefined: every request passes through the FIFO, with a minimum latency of 1 cycle.

## Structure
- Shared package `bg_vram_pkg`:
  - address-map constants (PMB/NTBL base, size, decode masks);
  - typedef `bg_vram_wr_t` {addr[11:0], data[7:0]};
  - typedef of the state enum.
- Sub-module `bg_vram_wr_fifo`: synchronous FIFO of `bg_vram_wr_t`, parameterised by DEPTH. It provides full/empty/count and a first-word-fall-through head.
- Decode, state register and backlog logic live in the top module.

## Test plan
- **Queue then drain:** with `writable` = 0, push 0x005←0xAA and 0x7FF←0x55. Expect `pending` = 2, `state` = WAIT, no strobes. Raise `writable`. Expect `pmb_we` with addr 0x005, data 0xAA, then next cycle `ntbl_we` with addr 0x3FF, data 0x55, then `state` = IDLE.
- **Unmapped:** push 0x200 and 0xC00 in a window. Expect two `unmapped` pulses, no strobes, `pending` back to 0.
- **Full:** with `writable` = 0, push DEPTH+1 writes. Expect `in_ready` = 0 after 16 and `pending` = 16. Open the window and hold a push in the same cycle. Expect the first retire, `pending` = 15, and the held push accepted next cycle.
- **Backlog:** queue 5 writes, then open `writable` for 2 cycles. Expect exactly 2 strobes, `backlog` = 1, `state` = WAIT, `pending` = 3. Pulse `backlog_clr` → `backlog` = 0.
- **Reset mid-drain:** assert `rst` = 0 during DRAIN with `pending` = 4. Expect strobes 0 immediately, and after release `pending` = 0, `state` = IDLE.
- **Bypass:** with the window open and the FIFO empty, push 0x010←0x3C. With the macro, `pmb_we` asserts the same cycle. Without it, `pmb_we` asserts the next cycle.
